// File: rtl/ball_motion_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ball_motion_sequencer
//
// Purpose: moves a square ball around a visible frame once per video frame.
// The direction, speed and enable inputs are sampled when frame_tick
// arrives. The ball is then moved one pixel per cycle on each active axis,
// for `speed` cycles. A step that would put the ball outside the visible
// area is dropped on that axis only, and the wall_hit output reports it at
// the end of the frame.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   frame_tick          one-cycle pulse at start of vertical blank
//   enable              motion enable (sampled with frame_tick)
//   up/down/left/right  direction requests (sampled with frame_tick)
//   speed[3:0]          pixels per frame (sampled with frame_tick)
//   ballX[9:0]          ball top-left X, registered
//   ballY[8:0]          ball top-left Y, registered
//   busy                high whenever a frame sequence is in progress
//   wall_hit            one-cycle pulse in DONE if any step was blocked
//   overrun             one-cycle pulse after a frame_tick that was dropped
// ---------------------------------------------------------------------------
module ball_motion_sequencer #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BALL_SIZE = 8,
  parameter int START_X   = 320,
  parameter int START_Y   = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic [3:0] speed,
  output logic [9:0] ballX,
  output logic [8:0] ballY,
  output logic       busy,
  output logic       wall_hit,
  output logic       overrun
);

  // Bounds are compared at 11 bits so that 0-1 shows up as a large value
  // and max+1 stays representable; neither case can wrap into range.
  localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  X_START = 10'(START_X);
  localparam logic [8:0]  Y_START = 9'(START_Y);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  spd_q, spd_d;
  logic        en_q, en_d;
  logic        x_pos_q, x_pos_d;
  logic        x_neg_q, x_neg_d;
  logic        y_pos_q, y_pos_d;
  logic        y_neg_q, y_neg_d;
  logic        blocked_q, blocked_d;
  logic        overrun_q, overrun_d;

  logic [10:0] x_wide, x_next;
  logic [10:0] y_wide, y_next;

  // State and datapath registers; reset places the ball at its start
  // position and abandons any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= X_START;
      y_q       <= Y_START;
      cnt_q     <= 4'd0;
      spd_q     <= 4'd0;
      en_q      <= 1'b0;
      x_pos_q   <= 1'b0;
      x_neg_q   <= 1'b0;
      y_pos_q   <= 1'b0;
      y_neg_q   <= 1'b0;
      blocked_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      spd_q     <= spd_d;
      en_q      <= en_d;
      x_pos_q   <= x_pos_d;
      x_neg_q   <= x_neg_d;
      y_pos_q   <= y_pos_d;
      y_neg_q   <= y_neg_d;
      blocked_q <= blocked_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state and datapath logic. The direction flags are one-hot per
  // axis (both clear means no motion on that axis). The inputs are taken
  // on the frame_tick edge, so any later change on them cannot affect a
  // frame that has already started.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    spd_d     = spd_q;
    en_d      = en_q;
    x_pos_d   = x_pos_q;
    x_neg_d   = x_neg_q;
    y_pos_d   = y_pos_q;
    y_neg_d   = y_neg_q;
    blocked_d = blocked_q;
    overrun_d = frame_tick && (state_q != IDLE);

    x_wide = {1'b0, x_q};
    y_wide = {2'b00, y_q};
    x_next = x_wide;
    y_next = y_wide;
    if (x_pos_q) begin
      x_next = x_wide + 11'd1;
    end else if (x_neg_q) begin
      x_next = x_wide - 11'd1;
    end
    if (y_pos_q) begin
      y_next = y_wide + 11'd1;
    end else if (y_neg_q) begin
      y_next = y_wide - 11'd1;
    end

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = LATCH;
          en_d    = enable;
          spd_d   = speed;
          x_pos_d = right & ~left;
          x_neg_d = left & ~right;
          y_pos_d = down & ~up;
          y_neg_d = up & ~down;
        end
      end

      LATCH: begin
        cnt_d = spd_q;
        if (en_q && (spd_q != 4'd0) &&
            (x_pos_q || x_neg_q || y_pos_q || y_neg_q)) begin
          state_d = STEP;
        end else begin
          state_d = DONE;
        end
      end

      // An underflowed coordinate (0-1) reads as a value far above the
      // bound, so one unsigned compare covers both edges of each axis.
      STEP: begin
        if (x_pos_q || x_neg_q) begin
          if (x_next > X_MAX) begin
            blocked_d = 1'b1;
          end else begin
            x_d = x_next[9:0];
          end
        end
        if (y_pos_q || y_neg_q) begin
          if (y_next > Y_MAX) begin
            blocked_d = 1'b1;
          end else begin
            y_d = y_next[8:0];
          end
        end
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
        end
      end

      DONE: begin
        blocked_d = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ballX    = x_q;
  assign ballY    = y_q;
  assign busy     = (state_q != IDLE);
  assign wall_hit = (state_q == DONE) && blocked_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_ball_motion_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ball_motion_sequencer
//
// Self-checking bench for ball_motion_sequencer. A table of hand-computed
// frames runs first. It is followed by directed corner sequences: wall
// clamp, input toggling mid-frame, overrun, and reset during motion.
// Randomized frames come last and are checked against a per-frame
// reference model that works out the end position with plain
// clamp arithmetic.
// ---------------------------------------------------------------------------
module tb_ball_motion_sequencer;

  localparam int XMAX = 632;
  localparam int YMAX = 472;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       enable;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic [3:0] speed;
  logic [9:0] ballX;
  logic [8:0] ballY;
  logic       busy;
  logic       wall_hit;
  logic       overrun;

  int testsRun;
  int testsFailed;
  int mx;
  int my;

  typedef struct {
    bit en;
    bit l;
    bit r;
    bit u;
    bit d;
    int spd;
    int ex;
    int ey;
    int ehit;
    int ebusy;
  } vec_t;

  vec_t vecs[8];

  ball_motion_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .enable    (enable),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .speed     (speed),
    .ballX     (ballX),
    .ballY     (ballY),
    .busy      (busy),
    .wall_hit  (wall_hit),
    .overrun   (overrun)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a wait is never satisfied.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model for one frame. It takes the request and the position
  // at frame start, and returns the end position, whether any wall blocked
  // the ball, and how many cycles busy stays high.
  function automatic void modelFrame(input int x0, input int y0, input bit en,
                                     input bit l, input bit r, input bit u,
                                     input bit d, input int spd,
                                     output int x1, output int y1,
                                     output int hit, output int blen);
    int dx;
    int dy;
    dx = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
    dy = (d && !u) ? 1 : ((u && !d) ? -1 : 0);
    x1 = x0;
    y1 = y0;
    hit = 0;
    blen = 2;
    if (en && spd != 0 && (dx != 0 || dy != 0)) begin
      blen = spd + 2;
      x1 = x0 + dx * spd;
      y1 = y0 + dy * spd;
      if (x1 > XMAX) begin x1 = XMAX; hit = 1; end
      if (x1 < 0)    begin x1 = 0;    hit = 1; end
      if (y1 > YMAX) begin y1 = YMAX; hit = 1; end
      if (y1 < 0)    begin y1 = 0;    hit = 1; end
    end
  endfunction

  task automatic doReset();
    rst_n = 1'b0;
    frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mx = 320;
    my = 240;
  endtask

  // Runs one frame, starting at #1 after a rising edge with the block idle.
  // extraAt > 0 raises a second frame_tick that many cycles after the
  // first. scramble randomizes the request inputs from the first STEP
  // cycle onward.
  task automatic applyStimulus(input bit en, input bit l, input bit r,
                               input bit u, input bit d, input logic [3:0] spd,
                               input bit scramble, input int extraAt,
                               output int busyCycles, output int hits,
                               output int overruns);
    int  cyc;
    bit  fin;
    enable = en; left = l; right = r; up = u; down = d; speed = spd;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    fin = 1'b0;
    busyCycles = 0;
    hits = 0;
    overruns = 0;
    while (!fin) begin
      frame_tick = (cyc == extraAt);
      if (busy) busyCycles++;
      if (wall_hit) hits++;
      if (overrun) overruns++;
      if (!busy) begin
        fin = 1'b1;
      end else begin
        if (scramble && cyc >= 2) begin
          {left, right, up, down} = 4'($urandom);
          enable = 1'($urandom);
          speed = 4'($urandom);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cyc > 60) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL frame timeout: busy still high after %0d cycles, expected at most 18", cyc);
          fin = 1'b1;
        end
      end
    end
    frame_tick = 1'b0;
  endtask

  // Model-checked frame: predicts the outcome, runs the frame, then compares.
  task automatic runChecked(input string name, input bit en, input bit l,
                            input bit r, input bit u, input bit d,
                            input int spd, input bit scramble, input int extraAt);
    int ex, ey, eh, eb, bc, hc, oc;
    modelFrame(mx, my, en, l, r, u, d, spd, ex, ey, eh, eb);
    applyStimulus(en, l, r, u, d, 4'(spd), scramble, extraAt, bc, hc, oc);
    checkOutput({name, " ballX"}, int'(ballX), ex);
    checkOutput({name, " ballY"}, int'(ballY), ey);
    checkOutput({name, " wall_hit"}, hc, eh);
    checkOutput({name, " busy cycles"}, bc, eb);
    checkOutput({name, " overrun"}, oc, (extraAt > 0) ? 1 : 0);
    mx = ex;
    my = ey;
  endtask

  initial begin
    int bc, hc, oc, pulses, waitCyc;
    bit l, r, u, d, en;
    int spd, ex, ey, eh, eb, extra;

    testsRun = 0;
    testsFailed = 0;
    rst_n = 1'b1;
    frame_tick = 1'b0;
    enable = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    speed = 4'd0;

    // Hand-computed frames, applied in order from the reset position.
    vecs[0] = '{en:1, l:0, r:1, u:0, d:1, spd:4,  ex:324, ey:244, ehit:0, ebusy:6};
    vecs[1] = '{en:1, l:1, r:0, u:1, d:0, spd:3,  ex:321, ey:241, ehit:0, ebusy:5};
    vecs[2] = '{en:1, l:1, r:1, u:1, d:0, spd:3,  ex:321, ey:238, ehit:0, ebusy:5};
    vecs[3] = '{en:0, l:0, r:1, u:0, d:0, spd:5,  ex:321, ey:238, ehit:0, ebusy:2};
    vecs[4] = '{en:1, l:0, r:1, u:0, d:0, spd:0,  ex:321, ey:238, ehit:0, ebusy:2};
    vecs[5] = '{en:1, l:0, r:0, u:0, d:0, spd:7,  ex:321, ey:238, ehit:0, ebusy:2};
    vecs[6] = '{en:1, l:0, r:1, u:1, d:1, spd:15, ex:336, ey:238, ehit:0, ebusy:17};
    vecs[7] = '{en:1, l:1, r:0, u:0, d:1, spd:15, ex:321, ey:253, ehit:0, ebusy:17};

    // Reset then idle: start position, not busy, no pulses.
    doReset();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (wall_hit || overrun || busy) pulses++;
    end
    checkOutput("reset ballX", int'(ballX), 320);
    checkOutput("reset ballY", int'(ballY), 240);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset idle activity", pulses, 0);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].en, vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d,
                    4'(vecs[i].spd), 1'b0, 0, bc, hc, oc);
      checkOutput($sformatf("vec%0d ballX", i), int'(ballX), vecs[i].ex);
      checkOutput($sformatf("vec%0d ballY", i), int'(ballY), vecs[i].ey);
      checkOutput($sformatf("vec%0d wall_hit", i), hc, vecs[i].ehit);
      checkOutput($sformatf("vec%0d busy cycles", i), bc, vecs[i].ebusy);
      checkOutput($sformatf("vec%0d overrun", i), oc, 0);
    end
    mx = 321;
    my = 253;

    // Conflicting horizontal request, with inputs scrambled during STEP.
    runChecked("lr-conflict scrambled", 1, 1, 1, 1, 0, 3, 1'b1, 0);

    // Second tick two cycles after the first: dropped, overrun once.
    runChecked("overrun", 1, 0, 1, 0, 0, 8, 1'b0, 2);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (busy || overrun) pulses++;
    end
    checkOutput("no second sequence", pulses, 0);

    // Climb to X=630, then push against the right wall.
    doReset();
    for (int i = 0; i < 20; i++) runChecked("climb right", 1, 0, 1, 0, 0, 15, 1'b0, 0);
    runChecked("climb right final", 1, 0, 1, 0, 0, 10, 1'b0, 0);
    checkOutput("at 630", int'(ballX), 630);
    runChecked("right wall", 1, 0, 1, 0, 1, 5, 1'b0, 0);
    checkOutput("right wall clamp", int'(ballX), 632);

    // Drive into the top-left corner to exercise 0-1.
    doReset();
    for (int i = 0; i < 23; i++) runChecked("top-left", 1, 1, 0, 1, 0, 15, 1'b0, 0);
    checkOutput("corner ballX", int'(ballX), 0);
    checkOutput("corner ballY", int'(ballY), 0);

    // Reset asserted mid-STEP at X=325.
    doReset();
    enable = 1'b1; left = 1'b0; right = 1'b1; up = 1'b0; down = 1'b0;
    speed = 4'd10;
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    waitCyc = 0;
    while (ballX != 10'd325 && waitCyc < 30) begin
      @(posedge clk);
      #1;
      waitCyc++;
    end
    checkOutput("reach 325", int'(ballX), 325);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset ballX", int'(ballX), 320);
    checkOutput("async reset ballY", int'(ballY), 240);
    checkOutput("async reset busy", int'(busy), 0);
    checkOutput("async reset wall_hit", int'(wall_hit), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mx = 320;
    my = 240;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("after reset busy", int'(busy), 0);
    runChecked("fresh after reset", 1, 0, 1, 0, 0, 2, 1'b0, 0);

    // Randomized frames with directional bias so that walls are reached,
    // and occasional dropped ticks.
    doReset();
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        if ((i / 40) == 0 || (i / 40) == 3) begin
          l = 0; r = 1; u = 0; d = 1;
        end else begin
          l = 1; r = 0; u = 1; d = 0;
        end
      end else begin
        {l, r, u, d} = 4'($urandom);
      end
      en = ($urandom_range(0, 9) != 0);
      spd = $urandom_range(0, 15);
      modelFrame(mx, my, en, l, r, u, d, spd, ex, ey, eh, eb);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, eb) : 0;
      runChecked("random", en, l, r, u, d, spd, 1'($urandom), extra);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
